// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: func3 codes, unit states and
// the special operand values used by the divide fast path.
package rv32m_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } md_state_t;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Stalls the pipeline while iterating, then pulses done for one cycle.
module ex_muldiv
   import rv32m_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      done_rd
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

   md_state_t state, state_nxt;

   logic [CNT_W-1:0]  cnt;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   op_a, op_b;
   logic              neg_q, neg_r;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   rem, quo;
   logic [XLEN-1:0]   res_q;

   logic              accept;
   logic              a_sgn, b_sgn, s1_neg, s2_neg;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_res;

   logic [2*XLEN-1:0] add_term, acc_nxt, prod;
   logic [CNT_W-1:0]  idx;
   logic [XLEN:0]     rem_sh, diff;
   logic [XLEN-1:0]   rem_nxt, quo_nxt;
   logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

   assign accept  = (state == IDLE) & start & ~flush;
   assign busy    = accept | (state == CALC);
   assign done    = (state == DONE);
   assign result  = done ? res_q : '0;
   assign done_rd = done ? rd_q : '0;

   // Operand decode at accept: sign flags, magnitudes, fast-path cases
   always_comb begin
      a_sgn    = (func3 == F3_MULH) | (func3 == F3_MULHSU) |
                 (func3 == F3_DIV)  | (func3 == F3_REM);
      b_sgn    = (func3 == F3_MULH) | (func3 == F3_DIV) |
                 (func3 == F3_REM);
      s1_neg   = a_sgn & src1[XLEN-1];
      s2_neg   = b_sgn & src2[XLEN-1];
      mag1     = s1_neg ? -src1 : src1;
      mag2     = s2_neg ? -src2 : src2;
      div_zero = func3[2] & (src2 == '0);
      div_ovf  = ((func3 == F3_DIV) | (func3 == F3_REM)) &
                 (src1 == INT_MIN) & (src2 == ALL_ONES);
      fast     = div_zero | div_ovf;
      if (div_zero)
         fast_res = func3[1] ? src1 : ALL_ONES;
      else
         fast_res = func3[1] ? '0 : INT_MIN;
   end

   // One shift-add and one restoring-divide step per CALC cycle
   always_comb begin
      add_term = op_b[cnt] ? ({{XLEN{1'b0}}, op_a} << cnt) : '0;
      acc_nxt  = acc + add_term;
      idx      = LAST - cnt;
      rem_sh   = {rem, op_a[idx]};
      diff     = rem_sh - {1'b0, op_b};
      rem_nxt  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_nxt  = quo;
      quo_nxt[idx] = ~diff[XLEN];
   end

   // Sign fix and result select for the final iteration
   always_comb begin
      prod    = neg_q ? -acc_nxt : acc_nxt;
      quo_fix = neg_q ? -quo_nxt : quo_nxt;
      rem_fix = neg_r ? -rem_nxt : rem_nxt;
      case (f3_q)
         F3_MUL:                       fin_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fin_res = quo_fix;
         default:                      fin_res = rem_fix;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; flush always returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = fast ? DONE : CALC;
         CALC: begin
            if (flush)            state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch the op at accept, iterate in CALC
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= '0;
         f3_q  <= '0;
         rd_q  <= '0;
         op_a  <= '0;
         op_b  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         acc   <= '0;
         rem   <= '0;
         quo   <= '0;
         res_q <= '0;
      end else if (accept) begin
         cnt   <= '0;
         f3_q  <= func3;
         rd_q  <= rd;
         op_a  <= mag1;
         op_b  <= mag2;
         neg_q <= s1_neg ^ s2_neg;
         neg_r <= s1_neg;
         acc   <= '0;
         rem   <= '0;
         quo   <= '0;
         if (fast) res_q <= fast_res;
      end else if (state == CALC && !flush) begin
         cnt <= cnt + 1'b1;
         acc <= acc_nxt;
         rem <= rem_nxt;
         quo <= quo_nxt;
         if (cnt == LAST) res_q <= fin_res;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
// Hand-computed vectors for multiply, divide, fast path, flush and reset.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  func3 = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic [4:0]  rd = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  done_rd;

   int checks = 0;
   int failures = 0;

   ex_muldiv dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .flush   (flush),
      .func3   (func3),
      .src1    (src1),
      .src2    (src2),
      .rd      (rd),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .done_rd (done_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op at a negedge (cycle T), hold start until done,
   // and check latency, busy profile, result and done_rd.
   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp,
                         input int lat);
      int n;
      bit seen;
      bit busy_bad;
      @(negedge clk);
      func3 = f;
      src1  = a;
      src2  = b;
      rd    = r;
      start = 1'b1;
      #1;
      chk({tag, "_busyT"}, 32'(busy), 32'd1);
      n = 0;
      seen = 0;
      busy_bad = 0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
         else if (!busy) busy_bad = 1;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_busyrun"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busydone"}, 32'(busy), 32'd0);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_rd"}, 32'(done_rd), 32'(r));
      start = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", result, 32'd0);
      chk("rst_rd", 32'(done_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
      run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
             32'hFFFF_FFFE, 33);
      run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,
             32'h0000_0000, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,
             32'hFFFF_FFFF, 33);
      run_op("mul_x0", 3'b000, 32'h0001_0000, 32'h0001_0003, 5'd0,
             32'h0003_0000, 33);
      run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
      run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
      run_op("divu", 3'b101, 32'hFFFF_FFF0, 32'd16, 5'd9, 32'h0FFF_FFFF, 33);
      run_op("divu0", 3'b101, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
      run_op("remu0", 3'b111, 32'h0000_1234, 32'd0, 5'd11, 32'h0000_1234, 1);
      run_op("rem0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 1);
      run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13,
             32'h8000_0000, 1);
      run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14,
             32'h0000_0000, 1);

      // Flush a DIVU in flight at T+10
      begin
         bit done_seen;
         done_seen = 0;
         @(negedge clk);
         func3 = 3'b101;
         src1  = 32'd1000;
         src2  = 32'd3;
         rd    = 5'd15;
         start = 1'b1;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) done_seen = 1;
         end
         flush = 1'b1;
         #1;
         chk("flush_busy_T10", 32'(busy), 32'd1);
         @(negedge clk);
         flush = 1'b0;
         start = 1'b0;
         #1;
         chk("flush_busy_T11", 32'(busy), 32'd0);
         chk("flush_done_T11", 32'(done), 32'd0);
         if (done) done_seen = 1;
         chk("flush_nodone", 32'(done_seen), 32'd0);
         run_op("mul_after_flush", 3'b000, 32'd12, 32'd12, 5'd16,
                32'd144, 33);
      end

      // Reset in the middle of a MUL at T+20
      @(negedge clk);
      func3 = 3'b000;
      src1  = 32'd5;
      src2  = 32'd6;
      rd    = 5'd17;
      start = 1'b1;
      for (int i = 1; i <= 20; i++) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_res", result, 32'd0);
      chk("mrst_busy1", 32'(busy), 32'd1);
      start = 1'b0;
      #1;
      chk("mrst_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd18, 32'd14, 33);

      @(negedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_res", result, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Accepts an M-extension op already decoded in ID/EX, plus forwarded operands.
- Holds the pipeline with a stall request while computing, then presents a one-cycle result for EX/MEM capture.
- Radix-2 shift-add multiply and restoring divide, 32 iterations each; special divide cases take a fast path.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  ID/EX holds a valid M-ext op (held high while stalled)
flush  input  1  synchronous kill of in-flight op (branch/trap redirect)
func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  input  32  forwarded rs1 value
src2  input  32  forwarded rs2 value
rd  input  5  destination register of the op
busy  output  1  stall request to PC, IF/ID and ID/EX
done  output  1  one-cycle result-valid pulse
result  output  32  final value; valid only while done=1
done_rd  output  5  rd captured at accept

Behaviour:
- Reset (rstn low, async): state IDLE, counter 0, all datapath registers 0, done=0, result=0, done_rd=0. Reset mid-operation abandons the op silently.
- States are IDLE, CALC and DONE.
- busy is combinational: (state==IDLE & start & !flush) | state==CALC. It is 0 in DONE, so the pipeline advances in the DONE cycle with the result available.
- IDLE to CALC: on start & !flush, latch func3 and rd. Latch the operand magnitudes and sign flags:
  - signed for MULH (both), MULHSU (src1 only), DIV/REM (both);
  - unsigned for MUL, MULHU, DIVU, REMU.
  - Counter is set to 0.
- IDLE to DONE (fast path) on start & !flush when the op is a divide and:
  - src2==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src1.
  - DIV/REM with src1==0x80000000 and src2==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC runs one iteration per cycle; the counter increments and the unit goes to DONE after the iteration with counter==31 (32 CALC cycles).
  - Multiply: 64-bit accumulator. If multiplier bit i is set, add the multiplicand shifted by i.
  - Divide: restoring. Shift the remainder left with the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- Sign fix happens on the transition into DONE. Negate the product if the signs differ. Negate the quotient if the signs differ. The remainder takes the sign of the dividend.
- Result select:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: done=1 and result/done_rd are valid for exactly one cycle. The unit then goes to IDLE unconditionally. start is ignored in DONE, because the same instruction is still in ID/EX.
- Latency with start first seen at cycle T: iterative path gives done at T+33; fast path gives done at T+1. busy is high for cycles T..T+32 (iterative) or T only (fast path).
- Back-to-back ops: a new start is accepted in the IDLE cycle after DONE, at the earliest T+34.
- flush forces IDLE from any state at the next edge and suppresses done. flush wins over a simultaneous start. A flush in DONE still lets that cycle's done be seen; the consumer must qualify it with its own flush.
- result is forced to 0 whenever done=0, so no stale data is visible.
- x0 destination: the op is computed normally; done_rd=0 and write suppression is the writeback stage's job.

Decomposition:
- Shared package rv32m_pkg holds:
  - the func3 localparams (F3_MUL … F3_REMU);
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
- Single module, no sub-module. The shared iteration datapath (64-bit accumulator, 33-bit remainder) is small enough to stay inline.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD (-3), start at T -> busy T..T+32, done at T+33, result 0xFFFFFFEB, done_rd = rd.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF,0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). Both done at T+33.
- DIVU 0x1234/0 -> done at T+1, result 0xFFFFFFFF, busy high only at T. REMU same operands -> 0x00001234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1.
- Start DIVU, assert flush at T+10 -> state IDLE at T+11, busy 0, no done pulse ever. A new MUL at T+12 completes normally at T+45.
- Drop rstn low at T+20 of a MUL -> done=0, result=0, busy=start only. After release, a fresh DIVU 100/7 gives 14 at T'+33.
